// File: rtl/gsim_sweep_ctrl.sv
// rtl/gsim_sweep_ctrl.sv - Gauss-Seidel sweep controller feeding the GSIM PE and streaming the solved x vector.
// Optional early exit on an unchanged sweep is built when GSIM_CONV_EN is defined.
module gsim_sweep_ctrl #(
    parameter int N_ITER = 100,
    parameter int PE_LAT = 2,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       b_in,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [33:0]       pe_in_1,
    output logic [33:0]       pe_in_2,
    output logic [33:0]       pe_in_3,
    output logic [33:0]       pe_in_4,
    output logic [33:0]       pe_in_5,
    output logic [33:0]       pe_in_6,
    output logic [15:0]       pe_b,
    input  logic [37:0]       pe_out,
    output logic [31:0]       x_out,
    output logic              x_valid,
    input  logic              x_ready,
    output logic              busy,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [2:0]        wait_q, wait_d;
    logic [31:0]       x_q [16];
    logic [31:0]       x_d [16];
    logic [15:0]       b_q [16];
    logic [15:0]       b_d [16];
    logic [33:0]       pe_q [6];
    logic [33:0]       pe_d [6];
    logic [15:0]       pe_b_q, pe_b_d;
    logic [31:0]       x_out_q, x_out_d;
    logic [31:0]       wb_val;
    logic [ITER_W-1:0] iter_inc;
    logic              sweep_done;
`ifdef GSIM_CONV_EN
    logic              changed_q, changed_d;
`endif

    function automatic logic [33:0] sext(input logic [31:0] v);
        return {{2{v[31]}}, v};
    endfunction

    function automatic logic [31:0] sat32(input logic [37:0] v);
        if ((&v[37:31]) || (~|v[37:31])) begin
            return v[31:0];
        end else if (v[37]) begin
            return 32'h8000_0000;
        end else begin
            return 32'h7FFF_FFFF;
        end
    endfunction

    assign wb_val   = sat32(pe_out);
    assign iter_inc = iter_q + ITER_W'(1);

`ifdef GSIM_CONV_EN
    // The i=15 write-back itself counts towards the sweep's change flag.
    assign sweep_done = (iter_inc == ITER_W'(N_ITER)) ||
                        !(changed_q || (wb_val != x_q[idx_q]));
`else
    assign sweep_done = (iter_inc == ITER_W'(N_ITER));
`endif

    assign b_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign x_valid  = (state_q == S_OUT);
    assign x_out    = x_out_q;
    assign iter_cnt = iter_q;
    assign pe_in_1  = pe_q[0];
    assign pe_in_2  = pe_q[1];
    assign pe_in_3  = pe_q[2];
    assign pe_in_4  = pe_q[3];
    assign pe_in_5  = pe_q[4];
    assign pe_in_6  = pe_q[5];
    assign pe_b     = pe_b_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        iter_d  = iter_q;
        wait_d  = wait_q;
        x_d     = x_q;
        b_d     = b_q;
        pe_d    = pe_q;
        pe_b_d  = pe_b_q;
        x_out_d = x_out_q;
`ifdef GSIM_CONV_EN
        changed_d = changed_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (b_valid) begin
                    b_d[0] = b_in;
                    idx_d  = 4'd1;
                    iter_d = '0;
                    for (int k = 0; k < 16; k++) begin
                        x_d[k] = '0;
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (b_valid) begin
                    b_d[idx_q] = b_in;
                    idx_d      = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Out-of-range neighbours read as zero; the 4-bit index wrap is masked by the guards.
                pe_d[0] = (idx_q <= 4'd12) ? sext(x_q[idx_q + 4'd3]) : '0;
                pe_d[1] = (idx_q >= 4'd3)  ? sext(x_q[idx_q - 4'd3]) : '0;
                pe_d[2] = (idx_q <= 4'd13) ? sext(x_q[idx_q + 4'd2]) : '0;
                pe_d[3] = (idx_q >= 4'd2)  ? sext(x_q[idx_q - 4'd2]) : '0;
                pe_d[4] = (idx_q <= 4'd14) ? sext(x_q[idx_q + 4'd1]) : '0;
                pe_d[5] = (idx_q >= 4'd1)  ? sext(x_q[idx_q - 4'd1]) : '0;
                pe_b_d  = b_q[idx_q];
`ifdef GSIM_CONV_EN
                if (idx_q == 4'd0) begin
                    changed_d = 1'b0;
                end
`endif
                if (PE_LAT == 1) begin
                    state_d = S_WB;
                end else begin
                    wait_d  = 3'(PE_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q <= 3'd1) begin
                    state_d = S_WB;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_WB: begin
                x_d[idx_q] = wb_val;
`ifdef GSIM_CONV_EN
                if (wb_val != x_q[idx_q]) begin
                    changed_d = 1'b1;
                end
`endif
                if (idx_q != 4'd15) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_ISSUE;
                end else begin
                    idx_d  = 4'd0;
                    iter_d = iter_inc;
                    if (sweep_done) begin
                        x_out_d = x_q[0];
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_OUT: begin
                if (x_ready) begin
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        x_out_d = x_q[idx_q + 4'd1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            iter_q  <= '0;
            wait_q  <= '0;
            pe_b_q  <= '0;
            x_out_q <= '0;
            for (int k = 0; k < 16; k++) begin
                x_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k < 6; k++) begin
                pe_q[k] <= '0;
            end
`ifdef GSIM_CONV_EN
            changed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            iter_q  <= iter_d;
            wait_q  <= wait_d;
            pe_b_q  <= pe_b_d;
            x_out_q <= x_out_d;
            x_q     <= x_d;
            b_q     <= b_d;
            pe_q    <= pe_d;
`ifdef GSIM_CONV_EN
            changed_q <= changed_d;
`endif
        end
    end

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// tb/tb_gsim_sweep_ctrl.sv - self-checking bench for gsim_sweep_ctrl with a PE stub and Gauss-Seidel reference model.
module tb_gsim_sweep_ctrl;

    localparam int N_IT = 3;
    localparam int LAT  = 2;
    localparam int ELEM = LAT + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] b_in = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [33:0] pe_in_1, pe_in_2, pe_in_3, pe_in_4, pe_in_5, pe_in_6;
    logic [15:0] pe_b;
    logic [37:0] pe_out;
    logic [31:0] x_out;
    logic        x_valid;
    logic        x_ready = 1'b0;
    logic        busy;
    logic [7:0]  iter_cnt;

    logic [15:0] b_in2 = '0;
    logic        b_valid2 = 1'b0;
    logic        b_ready2;
    logic [33:0] p2_1, p2_2, p2_3, p2_4, p2_5, p2_6;
    logic [15:0] pe_b2;
    logic [37:0] pe_out2;
    logic [31:0] x_out2;
    logic        x_valid2;
    logic        x_ready2 = 1'b0;
    logic        busy2;
    logic [7:0]  iter_cnt2;

    int          checks = 0;
    int          failures = 0;
    int          mode = 0;
    logic [37:0] stub_const = '0;
    logic [15:0] bvec [16];
    logic [31:0] exp_x [16];
    int          exp_sweeps;
    logic [31:0] beats_q [$];
    int          n_cyc;
    bit          timed_out;

    always #5 clk = ~clk;

    gsim_sweep_ctrl #(.N_ITER(N_IT), .PE_LAT(LAT), .ITER_W(8)) u_dut (
        .clk(clk), .reset(reset), .b_in(b_in), .b_valid(b_valid), .b_ready(b_ready),
        .pe_in_1(pe_in_1), .pe_in_2(pe_in_2), .pe_in_3(pe_in_3),
        .pe_in_4(pe_in_4), .pe_in_5(pe_in_5), .pe_in_6(pe_in_6),
        .pe_b(pe_b), .pe_out(pe_out), .x_out(x_out), .x_valid(x_valid),
        .x_ready(x_ready), .busy(busy), .iter_cnt(iter_cnt)
    );

    gsim_sweep_ctrl #(.N_ITER(100), .PE_LAT(2), .ITER_W(8)) u_dut_conv (
        .clk(clk), .reset(reset), .b_in(b_in2), .b_valid(b_valid2), .b_ready(b_ready2),
        .pe_in_1(p2_1), .pe_in_2(p2_2), .pe_in_3(p2_3),
        .pe_in_4(p2_4), .pe_in_5(p2_5), .pe_in_6(p2_6),
        .pe_b(pe_b2), .pe_out(pe_out2), .x_out(x_out2), .x_valid(x_valid2),
        .x_ready(x_ready2), .busy(busy2), .iter_cnt(iter_cnt2)
    );

    assign pe_out2 = 38'h10000;

    // PE behaviour as a function of the neighbour sum and b; shared by the stub and the model.
    function automatic logic [37:0] stub_fn(input int m, input longint s, input logic [15:0] bb);
        longint r;
        case (m)
            1:       r = (longint'(bb) + 1) << 16;
            2:       return stub_const;
            3:       r = (s >>> 1) - (longint'(bb) << 10) + 12345;
            default: r = 0;
        endcase
        return r[37:0];
    endfunction

    function automatic logic [31:0] sat_ref(input logic [37:0] v);
        longint sv;
        sv = longint'($signed(v));
        if (sv > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sv < -64'sd2147483648) return 32'h8000_0000;
        return sv[31:0];
    endfunction

    always_comb begin
        pe_out = stub_fn(mode,
                         longint'($signed(pe_in_1)) + longint'($signed(pe_in_2)) +
                         longint'($signed(pe_in_3)) + longint'($signed(pe_in_4)) +
                         longint'($signed(pe_in_5)) + longint'($signed(pe_in_6)), pe_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_solve(input int n_iter);
        logic [31:0] xm [16];
        longint      s;
        bit          chg;
        logic [31:0] nv;
        for (int k = 0; k < 16; k++) xm[k] = '0;
        exp_sweeps = 0;
        for (int it = 0; it < n_iter; it++) begin
            chg = 1'b0;
            for (int i = 0; i < 16; i++) begin
                s = 0;
                for (int d = 1; d <= 3; d++) begin
                    if (i + d < 16)  s += longint'($signed(xm[i + d]));
                    if (i - d >= 0)  s += longint'($signed(xm[i - d]));
                end
                nv = sat_ref(stub_fn(mode, s, bvec[i]));
                if (nv !== xm[i]) chg = 1'b1;
                xm[i] = nv;
            end
            exp_sweeps = it + 1;
`ifdef GSIM_CONV_EN
            if (!chg) break;
`endif
        end
        for (int k = 0; k < 16; k++) exp_x[k] = xm[k];
    endtask

    task automatic load_b();
        for (int k = 0; k < 16; k++) begin
            b_in = bvec[k];
            b_valid = 1'b1;
            for (int g = 0; g < 50 && !b_ready; g++) step();
            step();
        end
        b_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        n_cyc = 0;
        while (!x_valid && n_cyc < budget) begin
            step();
            n_cyc++;
        end
        timed_out = !x_valid;
    endtask

    task automatic collect();
        beats_q.delete();
        x_ready = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (x_valid) beats_q.push_back(x_out);
            step();
            if (beats_q.size() > 0 && !x_valid) break;
        end
        x_ready = 1'b0;
    endtask

    task automatic test_reset_state();
        checks++;
        if ({busy, b_ready, x_valid} !== 3'b010) begin
            failures++;
            $display("FAIL reset_flags got busy/b_ready/x_valid=%b exp=010", {busy, b_ready, x_valid});
        end
        checks++;
        if ({pe_in_1, pe_in_2, pe_in_3, pe_in_4, pe_in_5, pe_in_6, pe_b, x_out, iter_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_data got pe_in_1=%h pe_b=%h x_out=%h iter=%0d exp all zero",
                     pe_in_1, pe_b, x_out, iter_cnt);
        end
    endtask

    task automatic test_zero_solve();
        mode = 0;
        for (int k = 0; k < 16; k++) bvec[k] = '0;
        model_solve(N_IT);
        load_b();
        wait_out(N_IT * 16 * ELEM + 50);
        checks++;
        if (timed_out || n_cyc !== exp_sweeps * 16 * ELEM) begin
            failures++;
            $display("FAIL zero_latency got=%0d exp=%0d timeout=%0d", n_cyc, exp_sweeps * 16 * ELEM, timed_out);
        end
        checks++;
        if (iter_cnt !== 8'(exp_sweeps)) begin
            failures++;
            $display("FAIL zero_iter got=%0d exp=%0d", iter_cnt, exp_sweeps);
        end
        collect();
        checks++;
        if (beats_q.size() !== 16) begin
            failures++;
            $display("FAIL zero_beats got=%0d exp=16", beats_q.size());
        end
        for (int k = 0; k < beats_q.size() && k < 16; k++) begin
            checks++;
            if (beats_q[k] !== 32'h0) begin
                failures++;
                $display("FAIL zero_x[%0d] got=%h exp=0", k, beats_q[k]);
            end
        end
        checks++;
        if (b_ready !== 1'b1 || busy !== 1'b0 || iter_cnt !== 8'(exp_sweeps)) begin
            failures++;
            $display("FAIL zero_idle got b_ready=%b busy=%b iter=%0d exp 1 0 %0d", b_ready, busy, iter_cnt, exp_sweeps);
        end
    endtask

    task automatic test_neighbour_gather();
        int i;
        logic [33:0] e [6];
        logic [33:0] g [6];
        mode = 1;
        for (int k = 0; k < 16; k++) bvec[k] = 16'(k);
        model_solve(N_IT);
        load_b();
        // From sweep 1 on every x[k] holds (k+1)<<16, so sweep-2 operands follow directly.
        for (int n = 0; n < 2 * 16 * ELEM; n++) begin
            if (n >= 16 * ELEM && (n - 16 * ELEM) % ELEM == 1) begin
                i = (n - 16 * ELEM) / ELEM;
                e[0] = (i + 3 <= 15) ? 34'((i + 4) << 16) : '0;
                e[1] = (i - 3 >= 0)  ? 34'((i - 2) << 16) : '0;
                e[2] = (i + 2 <= 15) ? 34'((i + 3) << 16) : '0;
                e[3] = (i - 2 >= 0)  ? 34'((i - 1) << 16) : '0;
                e[4] = (i + 1 <= 15) ? 34'((i + 2) << 16) : '0;
                e[5] = (i - 1 >= 0)  ? 34'((i) << 16)     : '0;
                g[0] = pe_in_1; g[1] = pe_in_2; g[2] = pe_in_3;
                g[3] = pe_in_4; g[4] = pe_in_5; g[5] = pe_in_6;
                for (int p = 0; p < 6; p++) begin
                    checks++;
                    if (g[p] !== e[p]) begin
                        failures++;
                        $display("FAIL gather i=%0d pe_in_%0d got=%h exp=%h", i, p + 1, g[p], e[p]);
                    end
                end
                checks++;
                if (pe_b !== 16'(i)) begin
                    failures++;
                    $display("FAIL gather i=%0d pe_b got=%h exp=%h", i, pe_b, 16'(i));
                end
            end
            step();
        end
        wait_out(N_IT * 16 * ELEM + 50);
        collect();
        checks++;
        if (timed_out || beats_q.size() !== 16) begin
            failures++;
            $display("FAIL gather_beats got=%0d exp=16", beats_q.size());
        end
        for (int k = 0; k < beats_q.size() && k < 16; k++) begin
            checks++;
            if (beats_q[k] !== exp_x[k]) begin
                failures++;
                $display("FAIL gather_x[%0d] got=%h exp=%h", k, beats_q[k], exp_x[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [37:0] cv [3];
        logic [31:0] ev [3];
        cv[0] = 38'h0F_FFFF_FFFF; ev[0] = 32'h7FFF_FFFF;
        cv[1] = 38'h30_0000_0000; ev[1] = 32'h8000_0000;
        cv[2] = 38'h3F_FFFF_FFFE; ev[2] = 32'hFFFF_FFFE;
        for (int t = 0; t < 3; t++) begin
            mode = 2;
            stub_const = cv[t];
            for (int k = 0; k < 16; k++) bvec[k] = 16'($urandom);
            model_solve(N_IT);
            load_b();
            wait_out(N_IT * 16 * ELEM + 50);
            collect();
            checks++;
            if (timed_out || beats_q.size() !== 16) begin
                failures++;
                $display("FAIL sat%0d_beats got=%0d exp=16", t, beats_q.size());
            end
            for (int k = 0; k < beats_q.size() && k < 16; k++) begin
                checks++;
                if (beats_q[k] !== ev[t]) begin
                    failures++;
                    $display("FAIL sat%0d_x[%0d] got=%h exp=%h", t, k, beats_q[k], ev[t]);
                end
            end
        end
    endtask

    task automatic run_random_solve(input string tag);
        mode = 3;
        for (int k = 0; k < 16; k++) bvec[k] = 16'($urandom);
        model_solve(N_IT);
        load_b();
        wait_out(N_IT * 16 * ELEM + 50);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_random_solve("rand");
            checks++;
            if (timed_out || n_cyc !== exp_sweeps * 16 * ELEM || iter_cnt !== 8'(exp_sweeps)) begin
                failures++;
                $display("FAIL rand%0d_timing got cyc=%0d iter=%0d exp cyc=%0d iter=%0d",
                         r, n_cyc, iter_cnt, exp_sweeps * 16 * ELEM, exp_sweeps);
            end
            collect();
            checks++;
            if (beats_q.size() !== 16) begin
                failures++;
                $display("FAIL rand%0d_beats got=%0d exp=16", r, beats_q.size());
            end
            for (int k = 0; k < beats_q.size() && k < 16; k++) begin
                checks++;
                if (beats_q[k] !== exp_x[k]) begin
                    failures++;
                    $display("FAIL rand%0d_x[%0d] got=%h exp=%h", r, k, beats_q[k], exp_x[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        int stall = 0;
        int extra = 0;
        run_random_solve("bp");
        for (int c = 0; c < 100 && beats < 16; c++) begin
            if (beats == 3 && stall < 5) begin
                x_ready = 1'b0;
                checks++;
                if (x_out !== exp_x[3] || x_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold got x_out=%h x_valid=%b exp %h 1", x_out, x_valid, exp_x[3]);
                end
                stall++;
            end else begin
                x_ready = 1'b1;
            end
            if (x_valid && x_ready) begin
                checks++;
                if (x_out !== exp_x[beats]) begin
                    failures++;
                    $display("FAIL bp_x[%0d] got=%h exp=%h", beats, x_out, exp_x[beats]);
                end
                beats++;
            end
            step();
        end
        x_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (x_valid) extra++;
            step();
        end
        x_ready = 1'b0;
        checks++;
        if (beats !== 16 || stall !== 5 || extra !== 0 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_end got beats=%0d stall=%0d extra=%0d b_ready=%b exp 16 5 0 1",
                     beats, stall, extra, b_ready);
        end
    endtask

    task automatic test_reset();
        int leaks = 0;
        mode = 3;
        b_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            b_in = 16'($urandom);
            step();
        end
        b_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({busy, b_ready, x_valid} !== 3'b010 || iter_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_load_flags got busy/b_ready/x_valid=%b iter=%0d exp 010 0",
                     {busy, b_ready, x_valid}, iter_cnt);
        end
        checks++;
        if ({pe_in_1, pe_in_2, pe_in_3, pe_in_4, pe_in_5, pe_in_6, pe_b} !== '0) begin
            failures++;
            $display("FAIL rst_load_pe got pe_in_1=%h pe_in_5=%h pe_b=%h exp 0", pe_in_1, pe_in_5, pe_b);
        end
        run_random_solve("rst");
        collect();
        checks++;
        if (timed_out || beats_q.size() !== 16) begin
            failures++;
            $display("FAIL rst_solve_beats got=%0d exp=16", beats_q.size());
        end
        for (int k = 0; k < beats_q.size() && k < 16; k++) begin
            checks++;
            if (beats_q[k] !== exp_x[k]) begin
                failures++;
                $display("FAIL rst_solve_x[%0d] got=%h exp=%h", k, beats_q[k], exp_x[k]);
            end
        end
        run_random_solve("rst_out");
        x_ready = 1'b1;
        step(); step(); step();
        x_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (x_valid || busy) leaks++;
            step();
        end
        x_ready = 1'b0;
        checks++;
        if (leaks !== 0 || iter_cnt !== 8'd0 || x_out !== 32'h0) begin
            failures++;
            $display("FAIL rst_out got leaks=%0d iter=%0d x_out=%h exp 0 0 0", leaks, iter_cnt, x_out);
        end
    endtask

    task automatic test_convergence();
        int n = 0;
        int cnt = 0;
        mode = 2;
        stub_const = 38'h10000;
        for (int k = 0; k < 16; k++) bvec[k] = 16'($urandom);
        model_solve(100);
        b_valid2 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b_in2 = bvec[k];
            step();
        end
        b_valid2 = 1'b0;
        while (!x_valid2 && n < 100 * 48 + 100) begin
            step();
            n++;
        end
        checks++;
`ifdef GSIM_CONV_EN
        if (exp_sweeps !== 2 || iter_cnt2 !== 8'd2 || n !== 2 * 48) begin
`else
        if (exp_sweeps !== 100 || iter_cnt2 !== 8'd100 || n !== 100 * 48) begin
`endif
            failures++;
            $display("FAIL conv_iter got iter=%0d cyc=%0d exp iter=%0d cyc=%0d", iter_cnt2, n, exp_sweeps, exp_sweeps * 48);
        end
        x_ready2 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (x_valid2) begin
                checks++;
                if (x_out2 !== 32'h0001_0000) begin
                    failures++;
                    $display("FAIL conv_x[%0d] got=%h exp=00010000", cnt, x_out2);
                end
                cnt++;
            end
            step();
            if (cnt > 0 && !x_valid2) break;
        end
        x_ready2 = 1'b0;
        checks++;
        if (cnt !== 16 || b_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL conv_beats got=%0d b_ready=%b exp 16 1", cnt, b_ready2);
        end
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        test_reset_state();
        test_zero_solve();
        test_neighbour_gather();
        test_saturation();
        test_random();
        test_backpressure();
        test_reset();
        test_convergence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gsim_sweep_ctrl.md
Name: gsim_sweep_ctrl

Overview:
- Drives the GSIM processing element (PE) and consumes its result.
- Accepts the 16-entry b vector from the host and keeps the 16-entry x vector in a register file.
- Each step gathers the six neighbours of x[i] onto the PE input ports and writes the PE result back into x[i]; new values are used immediately (Gauss-Seidel ordering).
- After a fixed number of sweeps it streams the 16 x values to the host.

Parameters:
- N_ITER, 100: number of full sweeps (x[0]..x[15]) per solve; range 1..255.
- PE_LAT, 2: PE cycles from stable inputs to valid out; range 1..7.
- ITER_W, 8: width of iter_cnt.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- b_in  input  16  unsigned integer b value, host to block.
- b_valid  input  1  b_in valid.
- b_ready  output  1  block accepts b_in.
- pe_in_1 .. pe_in_6  output  34 each  PE neighbour operands, signed Q18.16.
- pe_b  output  16  b[i] to the PE.
- pe_out  input  38  PE result, signed Q22.16.
- x_out  output  32  solved x value, signed Q16.16.
- x_valid  output  1  x_out valid.
- x_ready  input  1  host accepts x_out.
- busy  output  1  high in every state except IDLE.
- iter_cnt  output  ITER_W  completed sweeps in the current solve.

Behaviour:
- Reset (synchronous, applied on any clk edge with reset=1, from any state):
  - State goes to IDLE; x[0..15] and b[0..15] are cleared.
  - All outputs go to 0, except b_ready, which is 1 in IDLE.
  - A reset mid-solve or mid-output discards all progress; no partial x beats are emitted afterwards.
- States: IDLE, LOAD, ISSUE, WAIT, WB, OUT.
- IDLE:
  - b_ready=1. A handshake (b_valid & b_ready) stores b_in into b[0] and moves to LOAD with load index 1.
- LOAD:
  - b_ready=1. Each handshake stores b[k] and increments k.
  - The handshake storing b[15] moves to ISSUE with i=0 and iter_cnt=0. x is all zero at solve start.
- ISSUE (1 cycle): registers the PE operands for element i.
  - pe_in_1=x[i+3], pe_in_2=x[i-3]
  - pe_in_3=x[i+2], pe_in_4=x[i-2]
  - pe_in_5=x[i+1], pe_in_6=x[i-1]
  - pe_b=b[i]
  - Any index outside 0..15 yields 0.
  - x values are sign-extended from 32 to 34 bits.
- WAIT: lasts PE_LAT-1 cycles; the PE ports hold their values. If PE_LAT=1, WAIT is skipped.
- WB (1 cycle): samples pe_out at the WB edge, i.e. PE_LAT cycles after the operands first appeared.
  - Writes x[i] = sat32(pe_out).
  - sat32: if pe_out[37:31] is all 0s or all 1s, the result is pe_out[31:0]; otherwise a positive value gives 32'h7FFF_FFFF and a negative value gives 32'h8000_0000.
  - If i<15: i++ and go to ISSUE.
  - If i=15: iter_cnt++ and i=0. If the new iter_cnt equals N_ITER, go to OUT with output index 0; otherwise go to ISSUE.
- Timing: each element takes PE_LAT+1 cycles and a sweep takes 16*(PE_LAT+1) cycles (48 with the defaults). The value written by WB is visible to the very next ISSUE.
- OUT:
  - x_valid=1 and x_out=x[j], registered.
  - A handshake (x_valid & x_ready) advances j. If x_ready is low, x_out and x_valid hold.
  - The handshake for j=15 returns the block to IDLE: x_valid drops on the next cycle, b_ready rises, and iter_cnt holds its final value until the next LOAD starts.
- b_ready=0 outside IDLE and LOAD. b_valid asserted in any other state is ignored and no data is consumed.
- pe_in_* and pe_b are held at their last value outside ISSUE/WAIT/WB; they are 0 only after reset.

Optional Feature:
- Macro: GSIM_CONV_EN.
- When defined:
  - A sweep_changed flag is cleared at i=0 ISSUE.
  - The flag is set when any WB writes a value different from the old x[i].
  - At the end of a sweep, if sweep_changed=0, the block goes to OUT immediately, even if iter_cnt < N_ITER.
  - iter_cnt then reports the sweeps actually executed.
- When not defined: exactly N_ITER sweeps always run; no flag logic is present.

Test Plan:
- Reset check: assert reset for 2 cycles from mid-LOAD -> next cycle busy=0, b_ready=1, x_valid=0, all pe_in_*=0, iter_cnt=0.
- Zero solve: load 16 b=0, PE stub returns 0, N_ITER=3 -> OUT after exactly 3*48 cycles past the last b handshake, 16 beats with x_out=0, iter_cnt=3.
- Neighbour gather: stub pe_out = {6'b0, i+1, 16'h0} -> during sweep 2:
  - ISSUE i=0 shows pe_in_2/4/6=0 and pe_in_5=x[1]=2<<16.
  - ISSUE i=15 shows pe_in_1/3/5=0.
  - ISSUE i=5 shows pe_in_1=x[8]=9<<16 and pe_in_6=x[4]=5<<16.
- Saturation: stub returns 38'h0F_FFFF_FFFF -> x=32'h7FFF_FFFF; stub returns 38'h30_0000_0000 -> x=32'h8000_0000; stub returns 38'h3F_FFFF_FFFE -> x=32'hFFFF_FFFE.
- Backpressure: in OUT, drop x_ready for 5 cycles at beat 3 -> x_out stays x[3] with x_valid=1, exactly 16 beats total, then b_ready=1.
- Convergence (GSIM_CONV_EN defined), N_ITER=100, stub returns constant 38'h10000 -> sweep 1 changes x, sweep 2 does not -> OUT entered with iter_cnt=2. With the macro undefined -> iter_cnt=100.
